// File: rtl/carrier_nco.sv
// Carrier NCO: phase accumulator with glitch-free tuning-word changes at phase
// wrap, quarter-wave sine table and a 3-stage registered output pipeline.
module carrier_nco #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned LUT_AW  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PHASE_W-1:0]  freq_word,
  input  logic                freq_load,
  input  logic                enable,
  input  logic                phase_sync,
  output logic signed [15:0]  mod_sin,
  output logic                sin_valid,
  output logic                phase_wrap
);

  localparam int unsigned LUT_N = 1 << LUT_AW;
  // pi/2 in Q62 fixed point
  localparam logic signed [127:0] HALF_PI_Q62 = 128'sh6487ED5110B4611A;

  // Elaboration-time table entry: round(32767*sin(pi/2*(k+0.5)/LUT_N)) via Taylor series in Q62.
  function automatic logic [14:0] tab_entry(input int unsigned k);
    logic signed [127:0] x;
    logic signed [127:0] x2;
    logic signed [127:0] term;
    logic signed [127:0] sum;
    x    = (HALF_PI_Q62 * $signed(128'(2 * k + 1))) >>> (LUT_AW + 1);
    x2   = (x * x) >>> 62;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> 62) / $signed(128'((2 * n) * (2 * n + 1)));
      sum  = sum + term;
    end
    return 15'((sum * 128'sd32767 + (128'sd1 <<< 61)) >>> 62);
  endfunction

  logic [14:0] rom [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_rom
    localparam logic [14:0] ENTRY = tab_entry(k);
    assign rom[k] = ENTRY;
  end

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] active_word;
  logic [PHASE_W-1:0] pending_word;
  logic               pending;
  logic               running;
  logic [PHASE_W:0]   sum_c;
  logic               wrap_c;

  assign sum_c  = {1'b0, acc} + {1'b0, active_word};
  assign wrap_c = enable & sum_c[PHASE_W];

  // Accumulator and word control; new words land only at phase zero (wrap or sync)
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      active_word  <= '0;
      pending_word <= '0;
      pending      <= 1'b0;
      running      <= 1'b0;
      phase_wrap   <= 1'b0;
    end else if (phase_sync) begin
      acc        <= '0;
      phase_wrap <= 1'b0;
      pending    <= 1'b0;
      if (freq_load) begin
        active_word <= freq_word;
        running     <= 1'b1;
      end else if (pending) begin
        active_word <= pending_word;
        running     <= 1'b1;
      end
    end else begin
      if (enable) acc <= sum_c[PHASE_W-1:0];
      phase_wrap <= wrap_c;
      if (wrap_c && freq_load) begin
        active_word <= freq_word;
        pending     <= 1'b0;
        running     <= 1'b1;
      end else if (wrap_c && pending) begin
        active_word <= pending_word;
        pending     <= 1'b0;
        running     <= 1'b1;
      end else if (freq_load) begin
        pending_word <= freq_word;
        pending      <= 1'b1;
      end
    end
  end

  logic [1:0]        quad1;
  logic [LUT_AW-1:0] idx1;
  logic              run1;
  logic              en1;
  logic              neg2;
  logic [14:0]       t2;
  logic              run2;
  logic              en2;

  // Stage 1: quadrant/address, stage 2: table read, stage 3: sign apply
  always_ff @(posedge clk) begin
    if (reset) begin
      quad1     <= '0;
      idx1      <= '0;
      run1      <= 1'b0;
      en1       <= 1'b0;
      neg2      <= 1'b0;
      t2        <= '0;
      run2      <= 1'b0;
      en2       <= 1'b0;
      mod_sin   <= '0;
      sin_valid <= 1'b0;
    end else begin
      quad1 <= acc[PHASE_W-1 -: 2];
      idx1  <= acc[PHASE_W-3 -: LUT_AW];
      run1  <= running;
      en1   <= enable;

      neg2 <= quad1[1];
      t2   <= quad1[0] ? rom[~idx1] : rom[idx1];
      run2 <= run1;
      en2  <= en1;

      if (!run2)     mod_sin <= '0;
      else if (neg2) mod_sin <= -$signed({1'b0, t2});
      else           mod_sin <= $signed({1'b0, t2});
      sin_valid <= en2;
    end
  end

endmodule

// File: tb/tb_carrier_nco.sv
// Randomized bench for carrier_nco against a real-arithmetic sine reference model.
module tb_carrier_nco;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        freq_word;
  logic               freq_load;
  logic               enable;
  logic               phase_sync;
  logic signed [15:0] mod_sin;
  logic               sin_valid;
  logic               phase_wrap;

  carrier_nco #(.PHASE_W(32), .LUT_AW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .freq_word  (freq_word),
    .freq_load  (freq_load),
    .enable     (enable),
    .phase_sync (phase_sync),
    .mod_sin    (mod_sin),
    .sin_valid  (sin_valid),
    .phase_wrap (phase_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              run;
    longint unsigned acc;
    bit              en;
  } samp_t;

  samp_t           pipe[$];
  int              tab[256];
  longint unsigned m_acc, m_active, m_pword;
  bit              m_pend, m_run, e_wrap, e_valid;
  int              e_sin;
  int              n_checks = 0;
  int              n_fail   = 0;
  int              cyc_n    = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc_n, got, exp);
    end
  endtask

  function automatic int ref_sample(samp_t s);
    int q;
    int i;
    if (!s.run) return 0;
    q = int'(s.acc >> 30);
    i = int'((s.acc >> 22) & 64'd255);
    case (q)
      0:       return tab[i];
      1:       return tab[255 - i];
      2:       return -tab[i];
      default: return -tab[255 - i];
    endcase
  endfunction

  // Behavioural model evaluated at each rising edge from the pre-edge state and inputs
  task automatic model_step();
    longint unsigned s;
    bit              wrap;
    samp_t           cur;
    samp_t           zero;
    if (reset) begin
      m_acc = 0; m_active = 0; m_pword = 0; m_pend = 0; m_run = 0; e_wrap = 0;
      zero = '{1'b0, 64'd0, 1'b0};
      pipe.delete();
      repeat (3) pipe.push_back(zero);
    end else begin
      cur = '{m_run, m_acc, enable};
      pipe.push_back(cur);
      void'(pipe.pop_front());
      s    = m_acc + m_active;
      wrap = enable && ((s >> 32) != 0);
      if (phase_sync) begin
        m_acc  = 0;
        e_wrap = 0;
        if (freq_load) begin m_active = 64'(freq_word); m_run = 1; end
        else if (m_pend) begin m_active = m_pword; m_run = 1; end
        m_pend = 0;
      end else begin
        e_wrap = wrap;
        if (enable) m_acc = s & 64'hFFFF_FFFF;
        if (wrap && (freq_load || m_pend)) begin
          m_active = freq_load ? 64'(freq_word) : m_pword;
          m_pend   = 0;
          m_run    = 1;
        end else if (freq_load) begin
          m_pword = 64'(freq_word);
          m_pend  = 1;
        end
      end
    end
    e_sin   = ref_sample(pipe[0]);
    e_valid = pipe[0].en;
  endtask

  task automatic cyc(input bit rst, input bit ld, input logic [31:0] w, input bit sy, input bit en);
    reset = rst; freq_load = ld; freq_word = w; phase_sync = sy; enable = en;
    @(posedge clk);
    model_step();
    #1;
    cyc_n++;
    check_eq("mod_sin", longint'(mod_sin), longint'(e_sin));
    check_eq("sin_valid", longint'(sin_valid), longint'(e_valid));
    check_eq("phase_wrap", longint'(phase_wrap), longint'(e_wrap));
  endtask

  task automatic run_gap(input int n, input int exp_gap, input string tag);
    int last = -1;
    int prev = -1;
    for (int j = 0; j < n; j++) begin
      cyc(0, 0, 32'd0, 0, 1);
      if (phase_wrap) begin prev = last; last = j; end
    end
    check_eq(tag, (prev >= 0) ? longint'(last - prev) : 0, longint'(exp_gap));
  endtask

  int         wave[8];
  int         exp_wave[4] = '{101, 32767, -101, -32767};
  bit         will;
  bit         found;

  initial begin
    for (int k = 0; k < 256; k++)
      tab[k] = $rtoi(32767.0 * $sin(3.14159265358979323846 / 2.0 * (k + 0.5) / 256.0) + 0.5);

    // Reset, then idle with enable: no word applied so output stays zero
    repeat (2) cyc(1, 0, 32'd0, 0, 0);
    repeat (6) cyc(0, 0, 32'd0, 0, 1);

    // Quarter-rate carrier started by load + sync
    cyc(0, 1, 32'h4000_0000, 1, 0);
    for (int j = 0; j < 8; j++) begin
      cyc(0, 0, 32'd0, 0, 1);
      wave[j] = int'(mod_sin);
    end
    for (int j = 0; j < 4; j++) check_eq("wave", longint'(wave[j + 2]), longint'(exp_wave[j]));

    // Mid-cycle load lands at the next wrap: period 4 -> 8
    cyc(0, 0, 32'd0, 0, 1);
    cyc(0, 1, 32'h2000_0000, 0, 1);
    run_gap(30, 8, "period_after_load");

    // Two loads before a wrap: last one wins (period 32)
    cyc(0, 1, 32'h4000_0000, 1, 1);
    cyc(0, 1, 32'h1000_0000, 0, 1);
    cyc(0, 1, 32'h0800_0000, 0, 1);
    run_gap(80, 32, "last_load_wins");

    // Load coinciding with a wrap applies the new word, not the pending one
    cyc(0, 1, 32'h2000_0000, 0, 1);
    found = 0;
    for (int j = 0; j < 64 && !found; j++) begin
      will = ((m_acc + m_active) >> 32) != 0;
      cyc(0, will, 32'h4000_0000, 0, 1);
      found = will;
    end
    check_eq("wrap_found", longint'(found), 1);
    run_gap(13, 4, "same_cycle_load");

    // Enable low for 5 cycles mid-waveform
    repeat (4) cyc(0, 0, 32'd0, 0, 1);
    repeat (5) cyc(0, 0, 32'd0, 0, 0);
    repeat (6) cyc(0, 0, 32'd0, 0, 1);

    // Sync at acc=0xC0000000 with same-cycle load: no wrap pulse
    cyc(0, 1, 32'h4000_0000, 1, 1);
    repeat (3) cyc(0, 0, 32'd0, 0, 1);
    cyc(0, 1, 32'h0100_0000, 1, 1);
    check_eq("sync_no_wrap", longint'(phase_wrap), 0);
    repeat (10) cyc(0, 0, 32'd0, 0, 1);

    // Reset with a pending word overrides everything; pending word is discarded
    cyc(0, 1, 32'h1000_0000, 0, 1);
    cyc(1, 1, 32'h2000_0000, 1, 1);
    check_eq("reset_out", longint'(mod_sin), 0);
    cyc(0, 0, 32'd0, 1, 1);
    repeat (10) cyc(0, 0, 32'd0, 0, 1);
    check_eq("pending_discarded", longint'(mod_sin), 0);

    // Randomized traffic
    for (int j = 0; j < 3000; j++)
      cyc($urandom_range(199) == 0, $urandom_range(9) == 0, $urandom >> $urandom_range(8),
          $urandom_range(49) == 0, $urandom_range(9) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/carrier_nco.md
CARRIER_NCO -- requirements
Module: carrier_nco

Interface
REQ-001 Parameter PHASE_W, default 32: phase accumulator and tuning word width.
REQ-002 Parameter LUT_AW, default 8: quarter-wave table address width (256 entries).
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port freq_word, input, PHASE_W: tuning word, increment per clk.
REQ-006 Port freq_load, input, 1: one-cycle strobe capturing freq_word as the pending word.
REQ-007 Port enable, input, 1: accumulator advances only while high.
REQ-008 Port phase_sync, input, 1: zeroes the phase and applies any pending word immediately.
REQ-009 Port mod_sin, output, 16 signed: carrier sample for the AM modulator.
REQ-010 Port sin_valid, output, 1: mod_sin corresponds to an enabled accumulator cycle.
REQ-011 Port phase_wrap, output, 1: one-cycle pulse per accumulator overflow.

Function
REQ-012 Registers: acc (PHASE_W), active_word, pending_word, pending flag.
- Each enabled cycle: acc <= acc + active_word, mod 2^PHASE_W.
- Disabled cycle: acc holds.
REQ-013 Carry out of the enabled add SHALL be the wrap event; phase_wrap is that carry, registered (asserted the cycle after the add).
REQ-014 freq_load SHALL set pending_word <= freq_word and pending <= 1.
- A second load before application overwrites pending_word (last load wins).
REQ-015 On a wrap event with pending=1: active_word <= pending_word, pending <= 0, effective from the next add.
- Changes land at phase zero: glitch-free.
REQ-016 freq_load coinciding with a wrap SHALL apply the newly loaded freq_word, not the older pending value.
REQ-017 phase_sync SHALL set acc <= 0 regardless of enable, overriding the increment, and produces no phase_wrap pulse.
- Pending word (including a same-cycle freq_load) becomes active immediately; pending cleared.
REQ-018 Quadrant and index from acc:
- q = acc[PHASE_W-1:PHASE_W-2]
- i = acc[PHASE_W-3:PHASE_W-2-LUT_AW]
REQ-019 Table entry T[k] = round(32767*sin(pi/2*(k+0.5)/2^LUT_AW)), unsigned 15-bit, stored as constants.
REQ-020 Sample by quadrant:
- q=0: +T[i]
- q=1: +T[~i]
- q=2: -T[i]
- q=3: -T[~i]
- Two's complement; -32768 never produced, so mod_sin lies in [-32767, 32767].
REQ-021 Pipeline SHALL be exactly 3 registered stages: acc -> address/quadrant -> table read -> sign apply/output.
- mod_sin reflects the acc value from 3 cycles earlier.
REQ-022 sin_valid SHALL be enable delayed by 3 cycles, aligned with mod_sin.
- Pipeline keeps flowing while enable is low, so mod_sin holds the last phase sample.
REQ-023 No handshake back-pressure: one sample per clk; consumer samples every cycle.

Reset
REQ-024 During reset, each of the following SHALL be 0 on the next edge: acc, active_word, pending_word, pending, all pipeline stages, mod_sin, sin_valid, phase_wrap.
REQ-025 Reset SHALL override phase_sync, freq_load and enable in the same cycle; a pending word is discarded.
REQ-026 After release, output stays 0 until a word is applied by phase_sync or a wrap.
- A wrap cannot occur with active_word=0, so startup requires phase_sync.

Verification
REQ-027 Reset; freq_word=0x40000000, freq_load, phase_sync; enable=1 -> mod_sin cycles +T[0], +T[255], -T[0], -T[255] (+101, +32767, -101, -32767); first sample 3 cycles after enable rises; phase_wrap every 4th cycle.
REQ-028 Active word 0x40000000; load 0x20000000 mid-cycle -> period stays 4 until next phase_wrap, then 8; no phase discontinuity.
REQ-029 Two loads (0x10000000, then 0x08000000) before a wrap -> only 0x08000000 applied; same-cycle load+wrap applies the new word.
REQ-030 enable low 5 cycles mid-waveform -> acc frozen; mod_sin holds constant; sin_valid low for exactly 5 cycles, delayed 3.
REQ-031 phase_sync at acc=0xC0000000 with load 0x01000000 same cycle -> acc=0 next cycle; new word used immediately; no phase_wrap.
REQ-032 Reset asserted mid-operation with pending set -> all outputs 0 one cycle later; pending discarded after release.
